op_window_stats: RTL
====================

# op_window_stats

Downstream consumer of the two-edge arithmetic stage. It takes that stage's sum result `c` and difference result `f` as a stream of samples and accumulates them over a window of `WIN` samples. At the end of each window it presents one summary record (sums, extremes, wrap count, sample count) through a valid/ready handshake. It sits between the arithmetic stage and any logging or checking logic, so that logic sees one record per window instead of one per sample.

## Interface
- `WIDTH`, 8: width of `c_in`, `f_in`, `max_c`, `min_f`.
- `SUM_W`, 16: width of the `sum_c` and `sum_f` accumulators.
- `WIN`, 4: samples per window, legal range 1..255.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  sample present on `c_in`/`f_in`.
- `in_ready`  output  1  block accepts a sample this cycle.
- `c_in`  input  WIDTH  sum result from the upstream stage.
- `f_in`  input  WIDTH  difference result from the upstream stage.
- `flush`  input  1  single-cycle pulse; closes a partial window.
- `out_valid`  output  1  summary record valid.
- `out_ready`  input  1  consumer accepts the record.
- `sum_c`, `sum_f`  output  SUM_W  saturating sums over the window.
- `max_c`  output  WIDTH  largest `c_in` in the window.
- `min_f`  output  WIDTH  smallest `f_in` in the window.
- `wrap_cnt`  output  8  samples in the window with `f_in > c_in` (upstream subtraction wrapped).
- `n_samples`  output  8  samples in this record (`WIN`, or fewer after a flush).

## Operation
- FSM with two states:
  - ACCUM: `in_ready`=1.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept rule: a sample is accepted when `in_valid && in_ready`. An accepted sample updates all internal accumulators:
  - `acc_c += c_in` and `acc_f += f_in`, each zero-extended and saturating at 2^SUM_W-1.
  - Running max of `c_in`. Running min of `f_in`; its internal reset value is all-ones.
  - `wrap` count +1 when `f_in > c_in`.
  - Sample count `cnt` +1.
- Window close happens in ACCUM when either:
  - the accepted sample brings `cnt` to `WIN`, or
  - `flush`=1 and the post-update `cnt` > 0.
- On window close:
  - Copy the post-update accumulators into the output registers. `n_samples` = post-update `cnt`.
  - Clear the internal accumulators; running min returns to all-ones.
  - Go to HOLD.
- Simultaneous accepted sample and `flush`: the sample is included, then the window closes.
- `flush` when `cnt`=0 and no sample is accepted: ignored.
- `flush` in HOLD: ignored and not remembered.
- HOLD → ACCUM on `out_valid && out_ready`: clear `out_valid`. Output data registers keep their last values.
- In HOLD, `in_valid` is ignored. The upstream producer must hold or drop samples; the block never buffers them.
- Sampling of `f_in` at posedge: the block captures the value the upstream stage updated on the preceding negedge. Pairing each `c`/`f` sample is the producer's responsibility, signalled by `in_valid`.

## Timing
- Reset (`rst_n`=0, asynchronous, any state):
  - Outputs: `out_valid`=0, `in_ready`=1; `sum_c`, `sum_f`, `max_c`, `min_f`, `wrap_cnt`, `n_samples` = 0.
  - State ACCUM; internal accumulators cleared.
- Reset mid-window discards the partial window. Reset in HOLD discards the pending record.
- Latency: the record is valid on the cycle after the posedge that accepts the closing sample (or the `flush`).
- `in_ready` drops in the same cycle `out_valid` rises.
- Output data registers are stable whenever `out_valid`=1 and must not change until the handshake completes.
- Handshake: ACCUM resumes the cycle after `out_valid && out_ready`. This gives one bubble cycle per window; the minimum window period is `WIN`+1 cycles.
- `out_ready` may be held high permanently: each record is then valid for exactly one cycle.

## Test plan
- WIN=4, stream (c,f) = (25,20), (50,42), (7,6), (150,130) with `out_ready`=1 → one record: `sum_c`=232, `sum_f`=198, `max_c`=150, `min_f`=6, `wrap_cnt`=0, `n_samples`=4.
- Wrap detection: samples (7,250), (10,5), (3,255), (0,0) → `wrap_cnt`=2, `min_f`=0, `max_c`=10, `sum_f`=510.
- Backpressure: first scenario with `out_ready`=0 for 5 cycles after `out_valid` rises → record stable, `in_ready`=0, the extra `in_valid` samples (99,99) do not appear in the next window; `out_ready`=1 → `out_valid` falls on the next cycle.
- Flush: samples (25,20), (50,42), then `flush` → `n_samples`=2, `sum_c`=75, `sum_f`=62, `max_c`=50, `min_f`=20. A second `flush` with `cnt`=0 produces no record.
- Saturation with SUM_W=9, WIN=4: four samples (255,255) → `sum_c`=`sum_f`=511.
- Reset mid-window: accept 3 samples, pulse `rst_n` low between clock edges → all outputs 0 immediately, `in_ready`=1; the next 4 samples (1,1) give `sum_c`=4, `n_samples`=4.

Source files
------------

// File: rtl/op_window_stats.sv
// Windowed statistics over the (c, f) sample stream from the arithmetic stage:
// one summary record per WIN samples (or per flush), handed off with valid/ready.
module op_window_stats #(
    parameter int WIDTH = 8,
    parameter int SUM_W = 16,
    parameter int WIN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] f_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_c,
    output logic [SUM_W-1:0] sum_f,
    output logic [WIDTH-1:0] max_c,
    output logic [WIDTH-1:0] min_f,
    output logic [7:0]       wrap_cnt,
    output logic [7:0]       n_samples
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [SUM_W-1:0] acc_c, acc_f, acc_c_nxt, acc_f_nxt;
    logic [WIDTH-1:0] run_max, run_min, max_nxt, min_nxt;
    logic [7:0]       wrap, cnt, wrap_nxt, cnt_nxt;
    logic             accept, close;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W+1)'(b);
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Post-update view of the window: what the accumulators become if this cycle's sample lands.
    always_comb begin
        acc_c_nxt = acc_c;
        acc_f_nxt = acc_f;
        max_nxt   = run_max;
        min_nxt   = run_min;
        wrap_nxt  = wrap;
        cnt_nxt   = cnt;
        if (accept) begin
            acc_c_nxt = sat_add(acc_c, c_in);
            acc_f_nxt = sat_add(acc_f, f_in);
            if (c_in > run_max) max_nxt = c_in;
            if (f_in < run_min) min_nxt = f_in;
            if (f_in > c_in) wrap_nxt = wrap + 8'd1;
            cnt_nxt = cnt + 8'd1;
        end
    end

    assign close = in_ready && ((accept && (cnt_nxt == 8'(WIN))) ||
                                (flush && (cnt_nxt != 8'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc_c     <= '0;
            acc_f     <= '0;
            run_max   <= '0;
            run_min   <= '1;
            wrap      <= '0;
            cnt       <= '0;
            sum_c     <= '0;
            sum_f     <= '0;
            max_c     <= '0;
            min_f     <= '0;
            wrap_cnt  <= '0;
            n_samples <= '0;
        end else if (state == ACCUM) begin
            if (close) begin
                sum_c     <= acc_c_nxt;
                sum_f     <= acc_f_nxt;
                max_c     <= max_nxt;
                min_f     <= min_nxt;
                wrap_cnt  <= wrap_nxt;
                n_samples <= cnt_nxt;
                acc_c     <= '0;
                acc_f     <= '0;
                run_max   <= '0;
                run_min   <= '1;
                wrap      <= '0;
                cnt       <= '0;
                state     <= HOLD;
            end else begin
                acc_c   <= acc_c_nxt;
                acc_f   <= acc_f_nxt;
                run_max <= max_nxt;
                run_min <= min_nxt;
                wrap    <= wrap_nxt;
                cnt     <= cnt_nxt;
            end
        end else if (out_ready) begin
            // Record holds its last value; accumulators were already cleared on close.
            state <= ACCUM;
        end
    end

endmodule
